// File: rtl/cml_pkg.sv
// Shared constants for the Camera Link receive path: clock-lane pattern,
// aligner state encoding, lane bit map and the word rotation helper.
package cml_pkg;

  localparam logic [6:0] CLK_PATTERN = 7'b1100011;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } align_state_e;

  // Positions in the aligned 28-bit word {lane3,lane2,lane1,lane0}.
  // Entry i is pixel bit i, where pixel = {portc, portb, porta}.
  localparam int PIX_MAP [24] = '{
    6, 5, 4, 3, 2, 1, 27, 26,
    0, 13, 12, 11, 10, 9, 25, 24,
    8, 7, 20, 19, 18, 17, 23, 22
  };
  localparam int LVAL_BIT = 16;
  localparam int FVAL_BIT = 15;
  localparam int DVAL_BIT = 14;

  function automatic logic [6:0] rotl7(input logic [6:0] w, input logic [2:0] r);
    logic [13:0] dbl;
    dbl = {w, w} << r;
    return dbl[13:7];
  endfunction

  function automatic logic [23:0] unpackPix(input logic [27:0] aw);
    logic [23:0] pix;
    pix = '0;
    for (int i = 0; i < 24; i++) begin
      pix[i] = aw[PIX_MAP[i]];
    end
    return pix;
  endfunction

endpackage

// File: rtl/cml_word_align.sv
// Clock-lane word aligner: hunts for the rotation that yields the clock
// pattern, holds it once locked, and registers the rotated data lanes.
module cml_word_align import cml_pkg::*; #(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  clk_word_i,
  input  logic [27:0] data_word_i,
  output logic        locked_o,
  output logic [2:0]  rot_o,
  output logic [27:0] aligned_o,
  output logic        lock_err_o
);

  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(UNLOCK_CNT + 1);

  align_state_e   state_q, state_d;
  logic [2:0]     rot_q, rot_d;
  logic [CW-1:0]  matchCnt_q, matchCnt_d;
  logic [MW-1:0]  missCnt_q, missCnt_d;
  logic           lockErr_q, lockErr_d;
  logic [27:0]    aligned_q;
  logic           patternHit;

  assign patternHit = (rotl7(clk_word_i, rot_q) == CLK_PATTERN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_HUNT;
      rot_q      <= '0;
      matchCnt_q <= '0;
      missCnt_q  <= '0;
      lockErr_q  <= 1'b0;
      aligned_q  <= '0;
    end else begin
      state_q    <= state_d;
      rot_q      <= rot_d;
      matchCnt_q <= matchCnt_d;
      missCnt_q  <= missCnt_d;
      lockErr_q  <= lockErr_d;
      aligned_q  <= {rotl7(data_word_i[27:21], rot_q), rotl7(data_word_i[20:14], rot_q),
                     rotl7(data_word_i[13:7], rot_q), rotl7(data_word_i[6:0], rot_q)};
    end
  end

  always_comb begin
    state_d    = state_q;
    rot_d      = rot_q;
    matchCnt_d = matchCnt_q;
    missCnt_d  = missCnt_q;
    lockErr_d  = lockErr_q;
    unique case (state_q)
      ST_HUNT: begin
        if (!patternHit) begin
          rot_d      = (rot_q == 3'd6) ? 3'd0 : rot_q + 3'd1;
          matchCnt_d = '0;
        end else if (matchCnt_q == CW'(LOCK_CNT - 1)) begin
          state_d    = ST_LOCKED;
          matchCnt_d = '0;
          missCnt_d  = '0;
        end else begin
          matchCnt_d = matchCnt_q + CW'(1);
        end
      end
      ST_LOCKED: begin
        if (patternHit) begin
          missCnt_d = '0;
        end else if (missCnt_q == MW'(UNLOCK_CNT - 1)) begin
          // Hunting resumes from the rotation that was last good.
          state_d    = ST_HUNT;
          lockErr_d  = 1'b1;
          missCnt_d  = '0;
          matchCnt_d = '0;
        end else begin
          missCnt_d = missCnt_q + MW'(1);
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  assign locked_o   = (state_q == ST_LOCKED);
  assign rot_o      = rot_q;
  assign aligned_o  = aligned_q;
  assign lock_err_o = lockErr_q;

endmodule

// File: rtl/cml_rx_deframer.sv
// Camera Link receive deframer: aligns the lanes, unpacks pixels and flags,
// and measures line length and lines per frame against the expected size.
module cml_rx_deframer import cml_pkg::*; #(
  parameter int ROW        = 1024,
  parameter int COL        = 1280,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic        clk_user,
  input  logic        rst,
  input  logic [6:0]  clk_word,
  input  logic [27:0] data_word,
  output logic        locked,
  output logic [2:0]  rot,
  output logic [23:0] pix_data,
  output logic        fval,
  output logic        lval,
  output logic        dval,
  output logic        pix_val,
  output logic [15:0] line_len,
  output logic [15:0] line_num,
  output logic        frame_done,
  output logic        size_err,
  output logic        lock_err
);

  logic [27:0] aligned;
  logic [23:0] pix_q;
  logic        fval_q, lval_q, dval_q;
  logic [15:0] pixCnt_q, pixCnt_d;
  logic [15:0] lineCnt_q, lineCnt_d;
  logic [15:0] lineLen_q, lineLen_d;
  logic [15:0] lineNum_q, lineNum_d;
  logic        lvalPrev_q, lvalPrev_d;
  logic        fvalPrev_q, fvalPrev_d;
  logic        frameDone_q, frameDone_d;
  logic        sizeErr_q, sizeErr_d;
  logic [15:0] lineCntAtEnd;
  logic        lineEnd, frameEnd;

  cml_word_align #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) u_align (
    .clk_i       (clk_user),
    .rst_i       (rst),
    .clk_word_i  (clk_word),
    .data_word_i (data_word),
    .locked_o    (locked),
    .rot_o       (rot),
    .aligned_o   (aligned),
    .lock_err_o  (lock_err)
  );

  always_ff @(posedge clk_user) begin
    if (rst) begin
      pix_q  <= '0;
      fval_q <= 1'b0;
      lval_q <= 1'b0;
      dval_q <= 1'b0;
    end else begin
      if (locked) begin
        pix_q <= unpackPix(aligned);
      end
      fval_q <= aligned[FVAL_BIT];
      lval_q <= aligned[LVAL_BIT];
      dval_q <= aligned[DVAL_BIT];
    end
  end

  assign pix_data = pix_q;
  assign fval     = locked & fval_q;
  assign lval     = locked & lval_q;
  assign dval     = locked & dval_q;
  assign pix_val  = fval & lval & dval;

  assign lineEnd  = lvalPrev_q & ~lval;
  assign frameEnd = fvalPrev_q & ~fval;

  // A line end coinciding with a frame end is counted before line_num loads.
  always_comb begin
    pixCnt_d     = pixCnt_q;
    lineCnt_d    = lineCnt_q;
    lineLen_d    = lineLen_q;
    lineNum_d    = lineNum_q;
    lvalPrev_d   = lval;
    fvalPrev_d   = fval;
    frameDone_d  = 1'b0;
    sizeErr_d    = sizeErr_q;
    lineCntAtEnd = lineCnt_q;
    if (!locked) begin
      pixCnt_d  = '0;
      lineCnt_d = '0;
    end else begin
      if (pix_val && pixCnt_q != 16'hFFFF) begin
        pixCnt_d = pixCnt_q + 16'd1;
      end
      if (lineEnd) begin
        lineLen_d    = pixCnt_q;
        pixCnt_d     = '0;
        lineCntAtEnd = (lineCnt_q == 16'hFFFF) ? lineCnt_q : lineCnt_q + 16'd1;
        lineCnt_d    = lineCntAtEnd;
        if (pixCnt_q != 16'(COL)) begin
          sizeErr_d = 1'b1;
        end
      end
      if (frameEnd) begin
        lineNum_d   = lineCntAtEnd;
        frameDone_d = 1'b1;
        pixCnt_d    = '0;
        lineCnt_d   = '0;
        if (lineCntAtEnd != 16'(ROW)) begin
          sizeErr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_user) begin
    if (rst) begin
      pixCnt_q    <= '0;
      lineCnt_q   <= '0;
      lineLen_q   <= '0;
      lineNum_q   <= '0;
      lvalPrev_q  <= 1'b0;
      fvalPrev_q  <= 1'b0;
      frameDone_q <= 1'b0;
      sizeErr_q   <= 1'b0;
    end else begin
      pixCnt_q    <= pixCnt_d;
      lineCnt_q   <= lineCnt_d;
      lineLen_q   <= lineLen_d;
      lineNum_q   <= lineNum_d;
      lvalPrev_q  <= lvalPrev_d;
      fvalPrev_q  <= fvalPrev_d;
      frameDone_q <= frameDone_d;
      sizeErr_q   <= sizeErr_d;
    end
  end

  assign line_len   = lineLen_q;
  assign line_num   = lineNum_q;
  assign frame_done = frameDone_q;
  assign size_err   = sizeErr_q;

endmodule

// File: tb/tb_cml_rx_deframer.sv
// Directed bench for cml_rx_deframer with a 4x8 frame geometry: alignment,
// loss of lock, pixel unpacking, frame measurement and reset recovery.
module tb_cml_rx_deframer;

  localparam logic [6:0] PAT = 7'b1100011;

  logic        clk_user;
  logic        rst;
  logic [6:0]  clk_word;
  logic [27:0] data_word;
  logic        locked;
  logic [2:0]  rot;
  logic [23:0] pix_data;
  logic        fval, lval, dval, pix_val;
  logic [15:0] line_len, line_num;
  logic        frame_done, size_err, lock_err;

  typedef struct {
    logic [23:0] pix;
    logic        fv, lv, dv;
    logic [23:0] expPix;
    logic        expFv, expLv, expDv, expPv;
  } vec_t;

  vec_t vecs [128];
  int   nVec;
  int   nCompared;
  int   nMismatched;
  int   fdCount;
  int   fdStart;
  int   inRot;
  bit   badClk;

  cml_rx_deframer #(
    .ROW        (4),
    .COL        (8),
    .LOCK_CNT   (16),
    .UNLOCK_CNT (4)
  ) dut (
    .clk_user   (clk_user),
    .rst        (rst),
    .clk_word   (clk_word),
    .data_word  (data_word),
    .locked     (locked),
    .rot        (rot),
    .pix_data   (pix_data),
    .fval       (fval),
    .lval       (lval),
    .dval       (dval),
    .pix_val    (pix_val),
    .line_len   (line_len),
    .line_num   (line_num),
    .frame_done (frame_done),
    .size_err   (size_err),
    .lock_err   (lock_err)
  );

  initial clk_user = 1'b0;
  always #5 clk_user = ~clk_user;

  always @(negedge clk_user) begin
    if (frame_done === 1'b1) fdCount++;
  end

  function automatic logic [6:0] rotRef(input logic [6:0] w, input int r);
    logic [6:0] o;
    for (int j = 0; j < 7; j++) o[j] = w[(j - r + 7) % 7];
    return o;
  endfunction

  function automatic logic [27:0] mkAligned(input logic [23:0] pix, input logic fv,
                                            input logic lv, input logic dv);
    logic [7:0] a, b, c;
    logic [6:0] l0, l1, l2, l3;
    a  = pix[7:0];
    b  = pix[15:8];
    c  = pix[23:16];
    l0 = {a[0], a[1], a[2], a[3], a[4], a[5], b[0]};
    l1 = {b[1], b[2], b[3], b[4], b[5], c[0], c[1]};
    l2 = {c[2], c[3], c[4], c[5], lv, fv, dv};
    l3 = {a[6], a[7], b[6], b[7], c[6], c[7], 1'b0};
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk_user);
    #1;
  endtask

  // Lanes are pre-rotated by inRot so the aligner must undo it with (7-inRot)%7.
  task automatic applyStimulus(input logic [23:0] pix, input logic fv, input logic lv,
                               input logic dv);
    logic [27:0] aw;
    aw        = mkAligned(pix, fv, lv, dv);
    data_word = {rotRef(aw[27:21], inRot), rotRef(aw[20:14], inRot),
                 rotRef(aw[13:7], inRot), rotRef(aw[6:0], inRot)};
    clk_word  = badClk ? (rotRef(PAT, inRot) ^ 7'b0010000) : rotRef(PAT, inRot);
  endtask

  task automatic checkOutput(input string name, input logic [95:0] got, input logic [95:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic addVec(input logic [23:0] pix, input logic fv, input logic lv, input logic dv);
    vecs[nVec].pix    = pix;
    vecs[nVec].fv     = fv;
    vecs[nVec].lv     = lv;
    vecs[nVec].dv     = dv;
    vecs[nVec].expPix = pix;
    vecs[nVec].expFv  = fv;
    vecs[nVec].expLv  = lv;
    vecs[nVec].expDv  = dv;
    vecs[nVec].expPv  = fv & lv & dv;
    nVec++;
  endtask

  task automatic addFrame(input int f, input int len0, input int len1, input int len2,
                          input int len3, input int tailBlank);
    int lens [4];
    lens = '{len0, len1, len2, len3};
    addVec(24'h0, 1'b1, 1'b0, 1'b0);
    for (int ln = 0; ln < 4; ln++) begin
      for (int c = 0; c < lens[ln]; c++) begin
        addVec({8'(8'hA0 + f), 8'(ln * 17 + 5), 8'(c * 29 + 3)}, 1'b1, 1'b1, 1'b1);
      end
      for (int k = 0; k < ((ln == 3) ? tailBlank : 2); k++) begin
        addVec(24'h0, 1'b1, 1'b0, 1'b0);
      end
    end
    addVec(24'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic compareVec(input int i);
    checkOutput($sformatf("vec%0d", i), {68'd0, pix_data, fval, lval, dval, pix_val},
                {68'd0, vecs[i].expPix, vecs[i].expFv, vecs[i].expLv, vecs[i].expDv,
                 vecs[i].expPv});
  endtask

  // Output seen after the edge that follows vector i belongs to vector i-1.
  task automatic runVectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      applyStimulus(vecs[i].pix, vecs[i].fv, vecs[i].lv, vecs[i].dv);
      tick();
      if (i > lo) compareVec(i - 1);
    end
    applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);
    tick();
    compareVec(hi);
    repeat (3) tick();
  endtask

  task automatic waitLock(input int maxCycles);
    int n;
    n = 0;
    while (locked !== 1'b1 && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput("lock_acquired", {95'd0, locked}, 96'd1);
  endtask

  task automatic checkFrame(input string tag, input int expNum, input logic expErr,
                            input int expFd);
    checkOutput({tag, "_line_len"}, {80'd0, line_len}, 96'd8);
    checkOutput({tag, "_line_num"}, {80'd0, line_num}, 96'(expNum));
    checkOutput({tag, "_size_err"}, {95'd0, size_err}, {95'd0, expErr});
    checkOutput({tag, "_frame_done_count"}, 96'(fdCount - fdStart), 96'(expFd));
  endtask

  function automatic logic [95:0] allOutputs();
    return {29'd0, locked, rot, pix_data, fval, lval, dval, pix_val, line_len, line_num,
            frame_done, size_err, lock_err};
  endfunction

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    fdCount     = 0;
    nVec        = 0;
    addFrame(0, 8, 8, 8, 8, 2);
    addFrame(1, 8, 8, 7, 8, 0);

    rst    = 1'b1;
    inRot  = 4;
    badClk = 1'b0;
    applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_outputs", allOutputs(), 96'd0);

    rst = 1'b0;
    waitLock(23);
    checkOutput("lock_rot3", {93'd0, rot}, 96'd3);
    checkOutput("lock_err_clean", {95'd0, lock_err}, 96'd0);

    applyStimulus(24'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("fval_while_locked", {95'd0, fval}, 96'd1);
    badClk = 1'b1;
    applyStimulus(24'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("locked_after_3_bad", {95'd0, locked}, 96'd1);
    badClk = 1'b0;
    applyStimulus(24'h0, 1'b1, 1'b0, 1'b0);
    tick();
    badClk = 1'b1;
    applyStimulus(24'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("locked_after_good_then_3_bad", {95'd0, locked}, 96'd1);
    tick();
    checkOutput("unlock_after_4_bad", {93'd0, locked, lock_err, fval}, 96'b010);
    checkOutput("no_frame_done_on_unlock", 96'(fdCount), 96'd0);
    badClk = 1'b0;
    applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);
    waitLock(40);
    checkOutput("relock_rot3", {93'd0, rot}, 96'd3);

    fdStart = fdCount;
    runVectors(0, 41);
    checkFrame("frame1", 4, 1'b0, 1);

    fdStart = fdCount;
    runVectors(42, nVec - 1);
    checkFrame("frame2", 4, 1'b1, 1);
    repeat (10) tick();
    checkOutput("sticky_errors", {94'd0, size_err, lock_err}, 96'b11);

    applyStimulus(24'h123456, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(24'h123456, 1'b1, 1'b1, 1'b1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checkOutput("midline_reset_outputs", allOutputs(), 96'd0);
    rst = 1'b0;
    applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);
    fdStart = fdCount;
    waitLock(23);
    checkOutput("post_reset_rot3", {93'd0, rot}, 96'd3);
    checkOutput("no_residual_frame_done", 96'(fdCount - fdStart), 96'd0);
    runVectors(0, 41);
    checkFrame("frame3", 4, 1'b0, 1);

    rst   = 1'b1;
    inRot = 2;
    applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    waitLock(23);
    checkOutput("lock_rot5", {93'd0, rot}, 96'd5);
    applyStimulus(24'hA5C33C, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("pixel_latency_1", {95'd0, pix_val}, 96'd0);
    applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("pixel_latency_2", {71'd0, pix_data, pix_val}, {71'd0, 24'hA5C33C, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/cml_rx_deframer.md
CML_RX_DEFRAMER -- requirements
Module: cml_rx_deframer

Interface
REQ-001 SHALL have parameter ROW, default 1024, expected lines per frame.
REQ-002 SHALL have parameter COL, default 1280, expected pixels per line.
REQ-003 SHALL have parameter LOCK_CNT, default 16, consecutive clock-pattern matches required to lock.
REQ-004 SHALL have parameter UNLOCK_CNT, default 4, consecutive mismatches that drop lock.
REQ-005 SHALL have port clk_user  in  1  word clock, one 7-bit word per lane per edge.
REQ-006 SHALL have port rst  in  1  reset; one clock, reset synchronous and active-high.
REQ-007 SHALL have port clk_word  in  7  deserialized clock-lane word, arbitrary bit rotation.
REQ-008 SHALL have port data_word  in  28  four deserialized data lanes, lane k on bits [7k+6:7k], same rotation as clk_word.
REQ-009 SHALL have port locked  out  1  word alignment locked.
REQ-010 SHALL have port rot  out  3  current rotation 0..6.
REQ-011 SHALL have port pix_data  out  24  {portc,portb,porta}.
REQ-012 SHALL have ports fval, lval, dval  out  1 each  decoded frame/line/data valid.
REQ-013 SHALL have port pix_val  out  1  locked & fval & lval & dval.
REQ-014 SHALL have ports line_len  out  16  and line_num  out  16  last measured pixels/line and lines/frame.
REQ-015 SHALL have ports frame_done  out  1  one-cycle pulse, and size_err, lock_err  out  1  sticky flags.

Function
REQ-016 SHALL define rot(w,r) = {w[6-r:0], w[6:7-r]}; r=0 is identity.
REQ-017 SHALL compare rot(clk_word,rot) against 7'b1100011 every cycle.
REQ-018 SHALL use FSM HUNT/LOCKED; in HUNT a mismatch advances rot (6 wraps to 0) and clears the match counter; a match increments it; reaching LOCK_CNT enters LOCKED.
REQ-019 SHALL, in LOCKED, hold rot; UNLOCK_CNT consecutive mismatches return to HUNT and set lock_err; any match clears the mismatch counter.
REQ-020 SHALL unpack the aligned lanes MSB-first: lane0={a0..a5,b0}, lane1={b1..b5,c0,c1}, lane2={c2..c5,LVAL,FVAL,DVAL}, lane3={a6,a7,b6,b7,c6,c7,spare}; spare ignored.
REQ-021 SHALL register rotation (stage 1) and unpacking (stage 2); latency 2 cycles from input word to pix_data/fval/lval/dval/pix_val.
REQ-022 SHALL force fval, lval, dval, pix_val to 0 while not locked; pix_data holds the last value.
REQ-023 SHALL count pix_val cycles per line; on lval 1->0 load line_len and increment the line counter; counter saturates at 16'hFFFF.
REQ-024 SHALL, on fval 1->0, load line_num, pulse frame_done for one cycle and clear the counters.
REQ-025 SHALL set size_err when a loaded line_len != COL or a loaded line_num != ROW.
REQ-026 SHALL clear the counters without updating line_len/line_num or pulsing frame_done when lock drops mid-frame.
REQ-027 SHALL treat simultaneous lval and fval falling edges as line end first, then frame end, in the same cycle.
REQ-028 SHALL clear size_err and lock_err only by rst.

Reset
REQ-029 SHALL, on rst, set FSM=HUNT, rot=0, all counters 0, and every output 0.
REQ-030 SHALL let rst abort alignment or a frame in progress with no residual pulse after release.

Structure
REQ-031 SHALL place the clock pattern 7'b1100011, the lane bit-map indices and the FSM state encoding in shared package cml_pkg.
REQ-032 SHALL implement the alignment FSM and rotator as sub-module cml_word_align; unpacking and measurement stay in the top.

Verification
REQ-033 SHALL cover: clk_word = rot(1100011,3) constant -> locked=1 and rot=3 no later than 7+16 cycles after rst release.
REQ-034 SHALL cover: after lock, 3 corrupted clock words -> stays locked; 4 consecutive -> locked=0, lock_err=1, fval=0 next cycle.
REQ-035 SHALL cover: one pixel 24'hA5C33C packed per REQ-020 with FVAL=LVAL=DVAL=1 at rotation 5 -> pix_data=24'hA5C33C, pix_val=1 exactly 2 cycles later.
REQ-036 SHALL cover: frame of ROW=4, COL=8 (parameter override) -> line_len=8, line_num=4, one frame_done pulse, size_err=0.
REQ-037 SHALL cover: one 7-pixel line in that frame -> size_err=1 and stays 1 until rst.
REQ-038 SHALL cover: rst asserted mid-line -> all outputs 0 one cycle later; re-lock and clean frame afterwards.
